// File: rtl/m68k_bus_target.sv
`default_nettype none
// ============================================================================
// Module   : m68k_bus_target
// Function : 68000 asynchronous-bus responder; forwards one CPU access per bus
//            cycle to a req/ack backend and returns DTACK after a minimum
//            number of wait states. Define M68K_BUS_TARGET_BERR_EN to enable
//            the backend timeout / bus-error path.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_bus_target #(
    parameter logic [22:0] BASE_ADDR   = 23'h000000,
    parameter logic [22:0] ADDR_MASK   = 23'h7FFF80,
    parameter int          WAIT_STATES = 0
`ifdef M68K_BUS_TARGET_BERR_EN
    ,
    parameter int          TIMEOUT     = 64
`endif
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        AS,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        RW,
    input  logic [22:0] ADDRESS,
    input  logic [15:0] DATA_I,
    output logic [15:0] DATA_O,
    output logic        DATA_OE,
    output logic        DTACK,
    output logic        BERR,
    output logic        be_req,
    output logic        be_we,
    output logic [22:0] be_addr,
    output logic [1:0]  be_sel,
    output logic [15:0] be_wdata,
    input  logic [15:0] be_rdata,
    input  logic        be_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_BERR = 2'd3
    } state_t;

    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

    logic        as_q, uds_q, lds_q, rw_q;
    logic [22:0] address_q;
    logic [15:0] data_i_q;

    state_t      state_q, state_d;
    logic [22:0] be_addr_q, be_addr_d;
    logic        be_we_q, be_we_d;
    logic [1:0]  be_sel_q, be_sel_d;
    logic [15:0] be_wdata_q, be_wdata_d;
    logic [15:0] data_o_q, data_o_d;
    logic [3:0]  wait_q, wait_d;
    logic        ack_seen_q, ack_seen_d;
    logic        abort_q, abort_d;

`ifdef M68K_BUS_TARGET_BERR_EN
    localparam int                C_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [C_TO_W-1:0] C_TO_LAST = C_TO_W'(TIMEOUT - 1);
    logic [C_TO_W-1:0] to_q, to_d;
`endif

    logic w_hit;
    logic w_done;

    assign w_hit  = ~as_q & (~uds_q | ~lds_q) &
                    ((address_q & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign w_done = be_ack | ack_seen_q;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            as_q       <= 1'b1;
            uds_q      <= 1'b1;
            lds_q      <= 1'b1;
            rw_q       <= 1'b1;
            address_q  <= '0;
            data_i_q   <= '0;
            state_q    <= S_IDLE;
            be_addr_q  <= '0;
            be_we_q    <= 1'b0;
            be_sel_q   <= '0;
            be_wdata_q <= '0;
            data_o_q   <= '0;
            wait_q     <= '0;
            ack_seen_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef M68K_BUS_TARGET_BERR_EN
            to_q       <= '0;
`endif
        end else begin
            as_q       <= AS;
            uds_q      <= UDS;
            lds_q      <= LDS;
            rw_q       <= RW;
            address_q  <= ADDRESS;
            data_i_q   <= DATA_I;
            state_q    <= state_d;
            be_addr_q  <= be_addr_d;
            be_we_q    <= be_we_d;
            be_sel_q   <= be_sel_d;
            be_wdata_q <= be_wdata_d;
            data_o_q   <= data_o_d;
            wait_q     <= wait_d;
            ack_seen_q <= ack_seen_d;
            abort_q    <= abort_d;
`ifdef M68K_BUS_TARGET_BERR_EN
            to_q       <= to_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        be_addr_d  = be_addr_q;
        be_we_d    = be_we_q;
        be_sel_d   = be_sel_q;
        be_wdata_d = be_wdata_q;
        data_o_d   = data_o_q;
        wait_d     = wait_q;
        ack_seen_d = ack_seen_q;
        abort_d    = abort_q;
`ifdef M68K_BUS_TARGET_BERR_EN
        to_d       = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                ack_seen_d = 1'b0;
                abort_d    = 1'b0;
                if (w_hit) begin
                    be_addr_d  = address_q;
                    be_we_d    = ~rw_q;
                    be_sel_d   = {~uds_q, ~lds_q};
                    be_wdata_d = data_i_q;
                    wait_d     = C_WAIT_INIT;
`ifdef M68K_BUS_TARGET_BERR_EN
                    to_d       = '0;
`endif
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                // Once AS has gone away the cycle is abandoned for good, even if AS returns.
                if (as_q) abort_d = 1'b1;
                if (be_ack && !ack_seen_q) begin
                    ack_seen_d = 1'b1;
                    if (!be_we_q) data_o_d = be_rdata;
                end
                if (w_done) begin
                    if (as_q || abort_q)        state_d = S_IDLE;
                    else if (wait_q == 4'd0)    state_d = S_ACK;
                end
`ifdef M68K_BUS_TARGET_BERR_EN
                else if (to_q == C_TO_LAST) state_d = S_BERR;
                else                        to_d    = to_q + 1'b1;
`endif
            end
            S_ACK: begin
                if (as_q) state_d = S_IDLE;
            end
            S_BERR: begin
                if (as_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign be_req   = (state_q == S_REQ) & ~ack_seen_q;
    assign be_we    = be_we_q;
    assign be_addr  = be_addr_q;
    assign be_sel   = be_sel_q;
    assign be_wdata = be_wdata_q;
    assign DATA_O   = data_o_q;
    assign DTACK    = (state_q != S_ACK);
    assign DATA_OE  = (state_q == S_ACK) & ~be_we_q;
`ifdef M68K_BUS_TARGET_BERR_EN
    assign BERR     = (state_q != S_BERR);
`else
    assign BERR     = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m68k_bus_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_m68k_bus_target
// Function : Self-checking bench; runs a zero-wait and a two-wait target side
//            by side on the same CPU bus and predicts them from bus-cycle rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_target;

    localparam logic [22:0] BASE = 23'h000100;
    localparam logic [22:0] MASK = 23'h7FFF80;

    logic        clk;
    logic        reset;
    logic        as_n, uds_n, lds_n, rw;
    logic [22:0] address;
    logic [15:0] data_i;
    logic [15:0] be_rdata;
    logic        be_ack;

    logic [15:0] data_o   [2];
    logic        data_oe  [2];
    logic        dtack    [2];
    logic        berr     [2];
    logic        be_req   [2];
    logic        be_we    [2];
    logic [22:0] be_addr  [2];
    logic [1:0]  be_sel   [2];
    logic [15:0] be_wdata [2];

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_last_rd = 16'h0000;

    m68k_bus_target #(
        .BASE_ADDR(BASE), .ADDR_MASK(MASK), .WAIT_STATES(0)
`ifdef M68K_BUS_TARGET_BERR_EN
        , .TIMEOUT(8)
`endif
    ) u_dut0 (
        .MCLK(clk), .reset(reset), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
        .ADDRESS(address), .DATA_I(data_i), .DATA_O(data_o[0]), .DATA_OE(data_oe[0]),
        .DTACK(dtack[0]), .BERR(berr[0]), .be_req(be_req[0]), .be_we(be_we[0]),
        .be_addr(be_addr[0]), .be_sel(be_sel[0]), .be_wdata(be_wdata[0]),
        .be_rdata(be_rdata), .be_ack(be_ack)
    );

    m68k_bus_target #(
        .BASE_ADDR(BASE), .ADDR_MASK(MASK), .WAIT_STATES(2)
`ifdef M68K_BUS_TARGET_BERR_EN
        , .TIMEOUT(8)
`endif
    ) u_dut2 (
        .MCLK(clk), .reset(reset), .AS(as_n), .UDS(uds_n), .LDS(lds_n), .RW(rw),
        .ADDRESS(address), .DATA_I(data_i), .DATA_O(data_o[1]), .DATA_OE(data_oe[1]),
        .DTACK(dtack[1]), .BERR(berr[1]), .be_req(be_req[1]), .be_we(be_we[1]),
        .be_addr(be_addr[1]), .be_sel(be_sel[1]), .be_wdata(be_wdata[1]),
        .be_rdata(be_rdata), .be_ack(be_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic bus_idle();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    endtask

    task automatic test_reset();
        logic [62:0] exp_v;
        reset = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        exp_v = {4'b0110, 1'b0, 2'b00, 23'h0, 16'h0, 16'h0};
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({be_req[d], dtack[d], berr[d], data_oe[d], be_we[d], be_sel[d],
                 be_addr[d], be_wdata[d], data_o[d]} !== exp_v) begin
                bad++;
                $display("FAIL reset_values dut%0d got %h want %h", d,
                         {be_req[d], dtack[d], berr[d], data_oe[d], be_we[d], be_sel[d],
                          be_addr[d], be_wdata[d], data_o[d]}, exp_v);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Expected timing: CPU strobes sampled at edge k; REQ cycle c lies after edge k+1+c.
    // The backend acks in REQ cycle ack_dly; DTACK falls after edge k+2+max(ack_dly, wait states).
    task automatic test_access(input logic rd, input logic [1:0] lanes, input logic [22:0] addr,
                               input logic [15:0] wdata, input logic [15:0] rdata,
                               input int ack_dly, input bit flip, input bit fast);
        bit          hit;
        int          dt_at [2];
        int          last;
        logic [3:0]  exp_ctl;
        logic [15:0] exp_do;
        hit      = ((addr & MASK) == (BASE & MASK));
        dt_at[0] = 2 + ack_dly;
        dt_at[1] = 2 + ((ack_dly > 2) ? ack_dly : 2);
        last     = hit ? dt_at[1] + 1 : 8;
        exp_do   = (hit && rd) ? rdata : exp_last_rd;
        as_n = 1'b0; uds_n = ~lanes[1]; lds_n = ~lanes[0]; rw = rd;
        address = addr; data_i = wdata;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            be_ack = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_ctl = {hit && j >= 1 && j <= 1 + ack_dly, !(hit && j >= dt_at[d]),
                           1'b1, hit && rd && j >= dt_at[d]};
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== exp_ctl) begin
                    bad++;
                    $display("FAIL access_ctl dut%0d j=%0d addr=%h got req/dtack/berr/oe=%b want %b",
                             d, j, addr, {be_req[d], dtack[d], berr[d], data_oe[d]}, exp_ctl);
                end
                if (hit && (j == 1 || j == last)) begin
                    total++;
                    if ({be_we[d], be_sel[d], be_addr[d], be_wdata[d]} !== {~rd, lanes, addr, wdata}) begin
                        bad++;
                        $display("FAIL access_be dut%0d j=%0d got we/sel/addr/wdata=%b/%b/%h/%h want %b/%b/%h/%h",
                                 d, j, be_we[d], be_sel[d], be_addr[d], be_wdata[d], ~rd, lanes, addr, wdata);
                    end
                end
                if (j == last || (hit && rd && j >= dt_at[d])) begin
                    total++;
                    if (data_o[d] !== exp_do) begin
                        bad++;
                        $display("FAIL access_data dut%0d j=%0d got %h want %h", d, j, data_o[d], exp_do);
                    end
                end
            end
            if (flip && j == 1) begin
                uds_n = 1'($urandom); lds_n = 1'($urandom); data_i = 16'($urandom);
            end
            if (hit && j == 1 + ack_dly) begin
                be_ack = 1'b1; be_rdata = rdata;
            end else begin
                be_rdata = 16'($urandom);
            end
        end
        bus_idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== {1'b0, !hit, 1'b1, hit && rd}) begin
                bad++;
                $display("FAIL release_hold dut%0d got %b want %b", d,
                         {be_req[d], dtack[d], berr[d], data_oe[d]}, {1'b0, !hit, 1'b1, hit && rd});
            end
        end
        if (!fast) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== 4'b0110) begin
                    bad++;
                    $display("FAIL release_done dut%0d got %b want 0110", d,
                             {be_req[d], dtack[d], berr[d], data_oe[d]});
                end
            end
        end
        exp_last_rd = exp_do;
    endtask

    task automatic test_read();
        test_access(1'b1, 2'b11, 23'h000104, 16'h0000, 16'hBEEF, 0, 1'b0, 1'b0);
    endtask

    task automatic test_byte_write();
        test_access(1'b0, 2'b01, 23'h000108, 16'h0055, 16'hC0DE, 0, 1'b0, 1'b0);
    endtask

    task automatic test_miss();
        test_access(1'b1, 2'b11, 23'h000200, 16'h1234, 16'hDEAD, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; address = BASE | 23'h10;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            be_ack = 1'b0;
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== {j >= 1 && j <= 6, 3'b110}) begin
                    bad++;
                    $display("FAIL abort_ctl dut%0d j=%0d got %b want %b", d, j,
                             {be_req[d], dtack[d], berr[d], data_oe[d]}, {j >= 1 && j <= 6, 3'b110});
                end
            end
            if (j == 2) bus_idle();
            if (j == 6) begin
                be_ack = 1'b1; be_rdata = 16'h5A3C;
            end
        end
        exp_last_rd = 16'h5A3C;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (data_o[d] !== exp_last_rd) begin
                bad++;
                $display("FAIL abort_data dut%0d got %h want %h", d, data_o[d], exp_last_rd);
            end
        end
    endtask

    task automatic test_idle_ack();
        bus_idle();
        @(negedge clk);
        be_ack = 1'b1; be_rdata = ~exp_last_rd;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            be_ack = 1'b0;
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d], data_o[d]} !== {4'b0110, exp_last_rd}) begin
                    bad++;
                    $display("FAIL idle_ack dut%0d got %b/%h want 0110/%h", d,
                             {be_req[d], dtack[d], berr[d], data_oe[d]}, data_o[d], exp_last_rd);
                end
            end
        end
    endtask

    task automatic test_reset_in_ack();
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; address = BASE; data_i = 16'hFFFF;
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            be_ack = (j == 1);
            be_rdata = 16'h1234;
        end
        for (int d = 0; d < 2; d++) begin
            total++;
            if (dtack[d] !== 1'b0) begin
                bad++;
                $display("FAIL rst_ack_pre dut%0d dtack got %b want 0", d, dtack[d]);
            end
        end
        reset = 1'b1;
        bus_idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({be_req[d], dtack[d], berr[d], data_oe[d], be_we[d], be_sel[d],
                 be_addr[d], be_wdata[d], data_o[d]} !== {4'b0110, 1'b0, 2'b00, 23'h0, 16'h0, 16'h0}) begin
                bad++;
                $display("FAIL rst_ack_post dut%0d got dtack=%b oe=%b sel=%b addr=%h do=%h want reset values",
                         d, dtack[d], data_oe[d], be_sel[d], be_addr[d], data_o[d]);
            end
        end
        reset = 1'b0;
        exp_last_rd = 16'h0000;
        test_access(1'b1, 2'b10, BASE | 23'h05, 16'h0, 16'h7E81, 1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        test_access(1'b1, 2'b10, BASE | 23'h01, 16'h1111, 16'hA5A5, 0, 1'b0, 1'b1);
        test_access(1'b0, 2'b11, BASE | 23'h02, 16'h2222, 16'h0F0F, 1, 1'b0, 1'b1);
        test_access(1'b1, 2'b01, BASE | 23'h03, 16'h3333, 16'h5A5A, 3, 1'b1, 1'b0);
    endtask

    task automatic test_random(input int n);
        logic [22:0] a;
        logic [1:0]  ln;
        for (int t = 0; t < n; t++) begin
            a = 23'($urandom);
            if ($urandom_range(0, 3) != 0) a = (BASE & MASK) | (a & ~MASK);
            ln = 2'($urandom_range(1, 3));
            test_access(1'($urandom), ln, a, 16'($urandom), 16'($urandom),
                        int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
        end
    endtask

`ifdef M68K_BUS_TARGET_BERR_EN
    task automatic test_timeout();
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1; address = BASE | 23'h20;
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            be_ack = 1'b0;
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== {j >= 1 && j <= 8, 1'b1, j < 9, 1'b0}) begin
                    bad++;
                    $display("FAIL timeout_ctl dut%0d j=%0d got %b want %b", d, j,
                             {be_req[d], dtack[d], berr[d], data_oe[d]}, {j >= 1 && j <= 8, 1'b1, j < 9, 1'b0});
                end
            end
        end
        bus_idle();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({be_req[d], dtack[d], berr[d], data_oe[d]} !== {2'b01, n == 1, 1'b0}) begin
                    bad++;
                    $display("FAIL timeout_release dut%0d n=%0d got %b want %b", d, n,
                             {be_req[d], dtack[d], berr[d], data_oe[d]}, {2'b01, n == 1, 1'b0});
                end
            end
        end
        test_access(1'b1, 2'b11, BASE | 23'h21, 16'h0, 16'h6789, 7, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1; be_ack = 1'b0; be_rdata = 16'h0; address = 23'h0; data_i = 16'h0;
        bus_idle();
        test_reset();
        test_read();
        test_byte_write();
        test_miss();
        test_abort();
        test_idle_ack();
        test_reset_in_ack();
        test_back_to_back();
        test_random(40);
`ifdef M68K_BUS_TARGET_BERR_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
